// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the parametrised UART transceiver family.
//   - PARITY_* : values accepted by the PARITY_MODE parameter
//   - TX_* / RX_* : 3-bit state encodings for the transmit and receive FSMs
//   - frame_bits() : number of bit times in one complete frame
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam logic [2:0] TX_IDLE  = 3'd0;
    localparam logic [2:0] TX_START = 3'd1;
    localparam logic [2:0] TX_DATA  = 3'd2;
    localparam logic [2:0] TX_PAR   = 3'd3;
    localparam logic [2:0] TX_STOP  = 3'd4;

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_PAR   = 3'd3;
    localparam logic [2:0] RX_STOP  = 3'd4;

    // Start bit, payload, optional parity bit and the stop bits.
    function automatic int frame_bits(input int data_bits, input int parity_mode, input int stop_bits);
        return 1 + data_bits + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_fifo_transceiver_if.sv
// uart_fifo_transceiver_if
// Host-side ready/valid bus of the UART transceiver.
//   data_in / data_in_valid / data_in_ready    : byte to transmit (host -> UART)
//   data_out / data_out_valid / data_out_ready : RX FIFO head (UART -> host)
// modport master : the host (CPU register block or testbench)
// modport slave  : the UART itself
interface uart_fifo_transceiver_if #(
    parameter int DATA_BITS = 8
);

    logic [DATA_BITS-1:0] data_in;
    logic                 data_in_valid;
    logic                 data_in_ready;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_out_valid;
    logic                 data_out_ready;

    modport master (
        output data_in,
        output data_in_valid,
        input  data_in_ready,
        input  data_out,
        input  data_out_valid,
        output data_out_ready
    );

    modport slave (
        input  data_in,
        input  data_in_valid,
        output data_in_ready,
        output data_out,
        output data_out_valid,
        input  data_out_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock first-word-fall-through FIFO.
//   clk, reset : system clock, asynchronous active-high reset (empties the FIFO)
//   push       : write push_data; ignored when full unless a pop happens in the same cycle
//   push_data  : word to write
//   pop        : remove the head word; ignored when empty
//   head       : current head word, valid whenever empty is low
//   full/empty : occupancy status
//   count      : number of stored words (0..DEPTH)
// DEPTH must be a power of two (pointers wrap by natural overflow) and at least 2.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // A pop on a full FIFO frees the slot the simultaneous push needs.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head = mem[rd_ptr];

    // Pointers and occupancy; a simultaneous push and pop leaves count alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the empty flag hides stale contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/uart_fifo_transceiver.sv
// uart_fifo_transceiver
// Parametrised UART with configurable width, parity and stop bits, and an RX FIFO.
//   clk, reset     : system clock, asynchronous active-high reset
//   host (slave)   : data_in/valid/ready transmit request, data_out/valid/ready RX FIFO head
//   serial_in      : RX line, asynchronous to clk
//   serial_out     : TX line, idles high
//   rx_count       : RX FIFO occupancy
//   parity_error   : sticky, a frame failed its parity check
//   framing_error  : sticky, a first stop bit was sampled low
//   overrun        : sticky, a good frame was dropped because the FIFO was full
//   clear_errors   : synchronous clear of the three sticky flags
module uart_fifo_transceiver
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ    = 50_000_000,
    parameter int BAUD_RATE     = 115_200,
    parameter int DATA_BITS     = 8,
    parameter int PARITY_MODE   = 0,
    parameter int STOP_BITS     = 1,
    parameter int RX_FIFO_DEPTH = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    uart_fifo_transceiver_if.slave             host,
    input  logic                               serial_in,
    output logic                               serial_out,
    output logic [$clog2(RX_FIFO_DEPTH+1)-1:0] rx_count,
    output logic                               parity_error,
    output logic                               framing_error,
    output logic                               overrun,
    input  logic                               clear_errors
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_SYMBOL      = SYMBOL_EDGE_TIME / 2;
    localparam int TW               = $clog2(SYMBOL_EDGE_TIME);
    localparam int BW               = $clog2(DATA_BITS + 1);
    localparam bit HAS_PARITY       = (PARITY_MODE != PARITY_NONE);

    // Parity bit the line should carry for a given payload.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (PARITY_MODE == PARITY_ODD) ? ~^d : ^d;
    endfunction

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    logic [2:0]           tx_state;
    logic [TW-1:0]        tx_timer;
    logic [BW-1:0]        tx_bit_idx;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par_bit;
    logic                 tx_tick;

    assign tx_tick            = (tx_timer == TW'(SYMBOL_EDGE_TIME - 1));
    assign host.data_in_ready = (tx_state == TX_IDLE);

    // serial_out is registered and updated on the same edge as the state,
    // so the line changes exactly when a new bit time begins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state   <= TX_IDLE;
            tx_timer   <= '0;
            tx_bit_idx <= '0;
            tx_shift   <= '0;
            tx_par_bit <= 1'b0;
            serial_out <= 1'b1;
        end else begin
            if (tx_state != TX_IDLE) begin
                tx_timer <= tx_tick ? '0 : tx_timer + 1'b1;
            end
            case (tx_state)
                TX_IDLE: begin
                    if (host.data_in_valid) begin
                        tx_state   <= TX_START;
                        tx_timer   <= '0;
                        tx_shift   <= host.data_in;
                        tx_par_bit <= parity_of(host.data_in);
                        serial_out <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_tick) begin
                        tx_state   <= TX_DATA;
                        tx_bit_idx <= '0;
                        serial_out <= tx_shift[0];
                    end
                end
                TX_DATA: begin
                    if (tx_tick) begin
                        if (tx_bit_idx == BW'(DATA_BITS - 1)) begin
                            tx_bit_idx <= '0;
                            if (HAS_PARITY) begin
                                tx_state   <= TX_PAR;
                                serial_out <= tx_par_bit;
                            end else begin
                                tx_state   <= TX_STOP;
                                serial_out <= 1'b1;
                            end
                        end else begin
                            tx_bit_idx <= tx_bit_idx + 1'b1;
                            tx_shift   <= tx_shift >> 1;
                            serial_out <= tx_shift[1];
                        end
                    end
                end
                TX_PAR: begin
                    if (tx_tick) begin
                        tx_state   <= TX_STOP;
                        tx_bit_idx <= '0;
                        serial_out <= 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_tick) begin
                        if (tx_bit_idx == BW'(STOP_BITS - 1)) begin
                            tx_state <= TX_IDLE;
                        end else begin
                            tx_bit_idx <= tx_bit_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    tx_state   <= TX_IDLE;
                    serial_out <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic                 rx_sync1;
    logic                 rx_sync2;
    logic                 rx_prev;
    logic                 rx_line;
    logic [2:0]           rx_state;
    logic [TW-1:0]        rx_timer;
    logic [BW-1:0]        rx_bit_idx;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par_bad;
    logic                 rx_mid;

    assign rx_line = rx_sync2;

    // The start bit is resampled half a bit after the edge; every later
    // sample is one full bit after the previous one, landing mid-bit.
    assign rx_mid = (rx_state == RX_START) ? (rx_timer == TW'(HALF_SYMBOL - 1))
                                           : (rx_timer == TW'(SYMBOL_EDGE_TIME - 1));

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    // Requiring a genuine 1->0 edge keeps a line held low after a framing
    // error from being mistaken for a new start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync1 <= 1'b1;
            rx_sync2 <= 1'b1;
            rx_prev  <= 1'b1;
        end else begin
            rx_sync1 <= serial_in;
            rx_sync2 <= rx_sync1;
            rx_prev  <= rx_sync2;
        end
    end

    // Receive FSM: collects the payload LSB first and remembers whether the
    // parity bit disagreed; the frame outcome is decided at the stop sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state   <= RX_IDLE;
            rx_timer   <= '0;
            rx_bit_idx <= '0;
            rx_shift   <= '0;
            rx_par_bad <= 1'b0;
        end else begin
            if (rx_state != RX_IDLE) begin
                rx_timer <= rx_mid ? '0 : rx_timer + 1'b1;
            end
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_line) begin
                        rx_state   <= RX_START;
                        rx_timer   <= '0;
                        rx_par_bad <= 1'b0;
                    end
                end
                RX_START: begin
                    if (rx_mid) begin
                        if (rx_line) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_state   <= RX_DATA;
                            rx_bit_idx <= '0;
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_mid) begin
                        rx_shift <= {rx_line, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit_idx == BW'(DATA_BITS - 1)) begin
                            rx_state <= HAS_PARITY ? RX_PAR : RX_STOP;
                        end else begin
                            rx_bit_idx <= rx_bit_idx + 1'b1;
                        end
                    end
                end
                RX_PAR: begin
                    if (rx_mid) begin
                        rx_par_bad <= (rx_line != parity_of(rx_shift));
                        rx_state   <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_mid) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame outcome, RX FIFO and sticky flags
    // ------------------------------------------------------------------
    logic stop_sample;
    logic frame_good;
    logic fifo_pop;
    logic fifo_full;
    logic fifo_empty;
    logic set_framing;
    logic set_parity;
    logic set_overrun;

    assign stop_sample = (rx_state == RX_STOP) && rx_mid;
    assign frame_good  = stop_sample && rx_line && !rx_par_bad;
    assign set_framing = stop_sample && !rx_line;
    assign set_parity  = stop_sample && rx_line && rx_par_bad;
    assign fifo_pop    = !fifo_empty && host.data_out_ready;
    assign set_overrun = frame_good && fifo_full && !fifo_pop;

    assign host.data_out_valid = !fifo_empty;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (frame_good),
        .push_data (rx_shift),
        .pop       (fifo_pop),
        .head      (host.data_out),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (rx_count)
    );

    // A new error in the same cycle as clear_errors keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            parity_error  <= set_parity  || (parity_error  && !clear_errors);
            framing_error <= set_framing || (framing_error && !clear_errors);
            overrun       <= set_overrun || (overrun       && !clear_errors);
        end
    end

endmodule

// File: tb/tb_uart_fifo_transceiver.sv
// tb_uart_fifo_transceiver
// Directed bench for uart_fifo_transceiver with two instances:
//   dut_a : defaults, 8N1 at 434 clocks per bit (RX, TX, glitch, reset mid-TX)
//   dut_b : even parity, 16 clocks per bit (parity, framing, overrun, push+pop when full)
module tb_uart_fifo_transceiver;
    import uart_pkg::*;

    localparam int BIT_A   = 434;
    localparam int FRAME_A = frame_bits(8, PARITY_NONE, 1) * BIT_A;
    localparam int BIT_B   = 16;

    logic       clk = 1'b0;
    logic       rst_a;
    logic       rst_b;
    logic       serial_a;
    logic       serial_b;
    logic       serial_out_a;
    logic       serial_out_b;
    logic [3:0] rx_count_a;
    logic [3:0] rx_count_b;
    logic       perr_a, ferr_a, ovr_a;
    logic       perr_b, ferr_b, ovr_b;
    logic       clear_a;
    logic       clear_b;

    int testsRun  = 0;
    int failCount = 0;

    uart_fifo_transceiver_if #(.DATA_BITS(8)) host_a ();
    uart_fifo_transceiver_if #(.DATA_BITS(8)) host_b ();

    always #5 clk = ~clk;

    uart_fifo_transceiver dut_a (
        .clk           (clk),
        .reset         (rst_a),
        .host          (host_a),
        .serial_in     (serial_a),
        .serial_out    (serial_out_a),
        .rx_count      (rx_count_a),
        .parity_error  (perr_a),
        .framing_error (ferr_a),
        .overrun       (ovr_a),
        .clear_errors  (clear_a)
    );

    uart_fifo_transceiver #(
        .CLOCK_FREQ  (1_600_000),
        .BAUD_RATE   (100_000),
        .PARITY_MODE (PARITY_EVEN)
    ) dut_b (
        .clk           (clk),
        .reset         (rst_b),
        .host          (host_b),
        .serial_in     (serial_b),
        .serial_out    (serial_out_b),
        .rx_count      (rx_count_b),
        .parity_error  (perr_b),
        .framing_error (ferr_b),
        .overrun       (ovr_b),
        .clear_errors  (clear_b)
    );

    // Count one comparison and report it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive a frame LSB first onto one RX line; each bit starts just after a falling clock edge.
    task automatic applyStimulus(input int which, input logic [11:0] bits, input int nbits, input int bit_time);
        for (int i = 0; i < nbits; i++) begin
            if (which == 0) serial_a = bits[i];
            else            serial_b = bits[i];
            repeat (bit_time) @(negedge clk);
        end
        if (which == 0) serial_a = 1'b1;
        else            serial_b = 1'b1;
    endtask

    function automatic logic [11:0] frameA(input logic [7:0] d);
        return {2'b11, 1'b1, d, 1'b0};
    endfunction

    function automatic logic [11:0] frameB(input logic [7:0] d, input logic par, input logic stop);
        return {stop, par, d, 1'b0};
    endfunction

    // Pop the dut_b head after confirming it.
    task automatic popB(input logic [7:0] expected, input string tag);
        checkOutput({tag, "_valid"}, 32'(host_b.data_out_valid), 32'd1);
        checkOutput({tag, "_data"}, 32'(host_b.data_out), 32'(expected));
        host_b.data_out_ready = 1'b1;
        @(negedge clk);
        host_b.data_out_ready = 1'b0;
    endtask

    // Launch a byte on dut_a and check the line at the first and last cycle of every bit.
    task automatic checkTxFrame(input logic [7:0] d, input string tag);
        logic [9:0] frame;
        frame = {1'b1, d, 1'b0};
        host_a.data_in       = d;
        host_a.data_in_valid = 1'b1;
        @(negedge clk);
        host_a.data_in_valid = 1'b0;
        for (int c = 0; c <= FRAME_A; c++) begin
            if (c == FRAME_A) begin
                checkOutput({tag, "_idle_line"}, 32'(serial_out_a), 32'd1);
                checkOutput({tag, "_ready_after"}, 32'(host_a.data_in_ready), 32'd1);
            end else begin
                if (c % BIT_A == 0 || c % BIT_A == BIT_A - 1)
                    checkOutput($sformatf("%s_bit%0d_%s", tag, c / BIT_A, (c % BIT_A == 0) ? "first" : "last"),
                                32'(serial_out_a), 32'(frame[c / BIT_A]));
                if (c == FRAME_A - 1)
                    checkOutput({tag, "_ready_busy"}, 32'(host_a.data_in_ready), 32'd0);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        logic [9:0] parTab;
        parTab = 10'b0011001011;

        rst_a = 1'b1;
        rst_b = 1'b1;
        serial_a = 1'b1;
        serial_b = 1'b1;
        clear_a = 1'b0;
        clear_b = 1'b0;
        host_a.data_in = '0;
        host_a.data_in_valid = 1'b0;
        host_a.data_out_ready = 1'b0;
        host_b.data_in = '0;
        host_b.data_in_valid = 1'b0;
        host_b.data_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);

        checkOutput("reset_serial_out", 32'(serial_out_a), 32'd1);
        checkOutput("reset_in_ready", 32'(host_a.data_in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(host_a.data_out_valid), 32'd0);
        checkOutput("reset_rx_count", 32'(rx_count_a), 32'd0);
        checkOutput("reset_flags", 32'({perr_a, ferr_a, ovr_a}), 32'd0);
        checkOutput("reset_flags_b", 32'({perr_b, ferr_b, ovr_b}), 32'd0);

        // 8N1 receive of 0x7A, then pop it.
        applyStimulus(0, frameA(8'h7A), 10, BIT_A);
        repeat (20) @(negedge clk);
        checkOutput("rx7a_valid", 32'(host_a.data_out_valid), 32'd1);
        checkOutput("rx7a_data", 32'(host_a.data_out), 32'h7A);
        checkOutput("rx7a_count", 32'(rx_count_a), 32'd1);
        host_a.data_out_ready = 1'b1;
        @(negedge clk);
        host_a.data_out_ready = 1'b0;
        checkOutput("rx7a_count_after_pop", 32'(rx_count_a), 32'd0);
        checkOutput("rx7a_valid_after_pop", 32'(host_a.data_out_valid), 32'd0);

        // 8N1 transmit of 0x7A: 0,0,1,0,1,1,1,1,0,1.
        checkTxFrame(8'h7A, "tx7a");

        // 100-cycle low pulse must be rejected at the start-bit resample.
        serial_a = 1'b0;
        repeat (100) @(negedge clk);
        serial_a = 1'b1;
        repeat (1000) @(negedge clk);
        checkOutput("glitch_count", 32'(rx_count_a), 32'd0);
        checkOutput("glitch_valid", 32'(host_a.data_out_valid), 32'd0);
        checkOutput("glitch_flags", 32'({perr_a, ferr_a, ovr_a}), 32'd0);

        // Reset while the transmitter is in the middle of the payload.
        host_a.data_in       = 8'h3C;
        host_a.data_in_valid = 1'b1;
        @(negedge clk);
        host_a.data_in_valid = 1'b0;
        repeat (3 * BIT_A) @(negedge clk);
        checkOutput("midtx_busy", 32'(host_a.data_in_ready), 32'd0);
        rst_a = 1'b1;
        #1;
        checkOutput("midtx_reset_line", 32'(serial_out_a), 32'd1);
        checkOutput("midtx_reset_ready", 32'(host_a.data_in_ready), 32'd1);
        @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        checkTxFrame(8'hC3, "txc3");

        // Even parity: 0x55 has four ones, so the correct parity bit is 0.
        applyStimulus(1, frameB(8'h55, 1'b1, 1'b1), 11, BIT_B);
        repeat (4) @(negedge clk);
        checkOutput("par_bad_flag", 32'(perr_b), 32'd1);
        checkOutput("par_bad_count", 32'(rx_count_b), 32'd0);
        applyStimulus(1, frameB(8'h55, 1'b0, 1'b1), 11, BIT_B);
        repeat (4) @(negedge clk);
        checkOutput("par_good_count", 32'(rx_count_b), 32'd1);
        checkOutput("par_sticky", 32'(perr_b), 32'd1);
        popB(8'h55, "par_pop");
        checkOutput("par_empty", 32'(rx_count_b), 32'd0);

        // Framing: 0xA5 with correct parity 0 but a low stop bit.
        applyStimulus(1, frameB(8'hA5, 1'b0, 1'b0), 11, BIT_B);
        repeat (4) @(negedge clk);
        checkOutput("frm_flag", 32'(ferr_b), 32'd1);
        checkOutput("frm_valid", 32'(host_b.data_out_valid), 32'd0);
        checkOutput("frm_count", 32'(rx_count_b), 32'd0);
        clear_b = 1'b1;
        @(negedge clk);
        clear_b = 1'b0;
        checkOutput("clear_framing", 32'(ferr_b), 32'd0);
        checkOutput("clear_parity", 32'(perr_b), 32'd0);

        // Nine bytes into an eight-entry FIFO without popping.
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(1, frameB(8'(i), parTab[i-1], 1'b1), 11, BIT_B);
            repeat (4) @(negedge clk);
        end
        checkOutput("ovr_count", 32'(rx_count_b), 32'd8);
        checkOutput("ovr_flag", 32'(ovr_b), 32'd1);
        checkOutput("ovr_other_flags", 32'({perr_b, ferr_b}), 32'd0);
        checkOutput("ovr_head", 32'(host_b.data_out), 32'h01);
        clear_b = 1'b1;
        @(negedge clk);
        clear_b = 1'b0;
        checkOutput("ovr_cleared", 32'(ovr_b), 32'd0);

        // FIFO full: pop exactly on the cycle of the stop sample of 0x0A
        // (170 clocks after the start edge at 16 clocks per bit).
        fork
            applyStimulus(1, frameB(8'h0A, parTab[9], 1'b1), 11, BIT_B);
            begin
                repeat (170) @(negedge clk);
                host_b.data_out_ready = 1'b1;
                @(negedge clk);
                host_b.data_out_ready = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        checkOutput("simul_count", 32'(rx_count_b), 32'd8);
        checkOutput("simul_overrun", 32'(ovr_b), 32'd0);
        for (int i = 2; i <= 8; i++) begin
            popB(8'(i), $sformatf("drain_%0d", i));
        end
        popB(8'h0A, "drain_0a");
        checkOutput("drain_count", 32'(rx_count_b), 32'd0);
        checkOutput("drain_valid", 32'(host_b.data_out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
